// File: rtl/imersiv_irq_rr_arbiter.sv
// Avalon-MM interrupt controller: captures rising edges on NUM_SRC lines and grants
// one pending, unmasked source at a time in round-robin order until software ACKs it.
module imersiv_irq_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    input  logic [NUM_SRC-1:0] src_in,
    output logic [31:0]        readdata,
    output logic               irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_VECTOR  = 2'd2;
    localparam logic [1:0] ADDR_ACK     = 2'd3;

    localparam logic [SRC_W:0]     NUM_SRC_EXT = (SRC_W+1)'(NUM_SRC);
    localparam logic [NUM_SRC-1:0] ONE_HOT_LSB = {{(NUM_SRC-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [NUM_SRC-1:0] sync_d1_r;
    logic [NUM_SRC-1:0] sync_d2_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] mask_r;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   grant_id_r;
    logic               irq_r;
    logic [31:0]        readdata_r;

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] pending_clr_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [SRC_W-1:0]   pick_s;
    logic               any_eligible_s;
    logic               wr_s;
    logic               rd_s;
    logic               ack_s;
    logic               mask_wr_s;
    logic [31:0]        rd_mux_s;
    logic               unused_wdata_s;

    // Increment a source index, wrapping NUM_SRC-1 back to 0.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] id);
        logic [SRC_W:0] sum;
        sum = {1'b0, id} + {{SRC_W{1'b0}}, 1'b1};
        if (sum >= NUM_SRC_EXT) begin
            sum = '0;
        end else begin
            sum = sum;
        end
        return sum[SRC_W-1:0];
    endfunction

    // First eligible index scanning from ptr upwards modulo NUM_SRC; descending loop lets the
    // nearest index overwrite farther ones.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] elig,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [NUM_SRC-1:0] rot;
        logic [SRC_W:0]     sum;
        logic [SRC_W-1:0]   result;
        rot    = NUM_SRC'({elig, elig} >> ptr);
        result = '0;
        sum    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (SRC_W+1)'(k);
                if (sum >= NUM_SRC_EXT) begin
                    sum = sum - NUM_SRC_EXT;
                end else begin
                    sum = sum;
                end
                result = sum[SRC_W-1:0];
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Bus decode, edge detect, arbitration and pending update.
    always_comb begin
        wr_s           = chipselect & ~write_n;
        rd_s           = chipselect & write_n;
        mask_wr_s      = wr_s & (address == ADDR_MASK);
        ack_s          = wr_s & (address == ADDR_ACK) & (state_r == ST_GRANTED);
        edge_s         = sync_d1_r & ~sync_d2_r;
        eligible_s     = pending_r & mask_r;
        any_eligible_s = |eligible_s;
        pick_s         = rr_pick(eligible_s, rr_ptr_r);
        unused_wdata_s = ^writedata;
        if (ack_s) begin
            pending_clr_s = ONE_HOT_LSB << grant_id_r;
        end else begin
            pending_clr_s = '0;
        end
        // A new edge on the granted source wins over the ACK clear.
        pending_nxt_s = (pending_r & ~pending_clr_s) | edge_s;
    end

    // Read data selection.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            ADDR_PENDING: rd_mux_s[NUM_SRC-1:0] = pending_r;
            ADDR_MASK:    rd_mux_s[NUM_SRC-1:0] = mask_r;
            ADDR_VECTOR: begin
                rd_mux_s[31]        = (state_r == ST_GRANTED);
                rd_mux_s[SRC_W-1:0] = grant_id_r;
            end
            ADDR_ACK:     rd_mux_s = 32'h0000_0000;
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Two-flop synchronizer per source line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d1_r <= '0;
            sync_d2_r <= '0;
        end else begin
            sync_d1_r <= src_in;
            sync_d2_r <= sync_d1_r;
        end
    end

    // Pending and mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= '0;
            mask_r    <= '0;
        end else begin
            pending_r <= pending_nxt_s;
            if (mask_wr_s) begin
                mask_r <= writedata[NUM_SRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Registered read data; only updated on a selected read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'h0000_0000;
        end else if (rd_s) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    // Grant FSM; irq is registered alongside the state so it mirrors GRANTED exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
            irq_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_eligible_s) begin
                        state_r    <= ST_GRANTED;
                        grant_id_r <= pick_s;
                        irq_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        irq_r   <= 1'b0;
                    end
                end
                ST_GRANTED: begin
                    if (ack_s) begin
                        state_r  <= ST_RELEASE;
                        rr_ptr_r <= wrap_inc(grant_id_r);
                        irq_r    <= 1'b0;
                    end else begin
                        state_r <= ST_GRANTED;
                        irq_r   <= 1'b1;
                    end
                end
                // One idle clock so level-sensitive CPUs observe the deassertion.
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                    irq_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_imersiv_irq_rr_arbiter.sv
// Directed self-checking bench for imersiv_irq_rr_arbiter: read results and grant order
// are queued as expectations when stimulus is applied and checked when the DUT responds.
module tb_imersiv_irq_rr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  src_in;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_q[$];
    logic [31:0] grant_q[$];

    imersiv_irq_rr_arbiter #(.NUM_SRC(4), .SRC_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .src_in     (src_in),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] e;
        rd_q.push_back(exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        e = rd_q.pop_front();
        chk(tag, readdata, e);
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, irq}, 32'h1);
    endtask

    // Wait for the next grant, check VECTOR against the queued order, then ACK it.
    task automatic take_grant(input string tag);
        logic [31:0] e;
        e = grant_q.pop_front();
        wait_irq({tag, "_irq"}, 8);
        bus_read({tag, "_vec"}, 2'd2, e);
        bus_write(2'd3, 32'h1);
        chk({tag, "_ackdrop"}, {31'h0, irq}, 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int grants;
        logic saw_irq;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        src_in     = 4'h0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        chk("rst_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) bus_read("rst_reg", 2'(a), 32'h0);

        // Single event on src 2: irq on third edge
        bus_write(2'd1, 32'hF);
        bus_read("mask_rb", 2'd1, 32'hF);
        src_in[2] = 1'b1;
        tick();
        tick();
        chk("lat_irq_early", {31'h0, irq}, 32'h0);
        tick();
        chk("lat_irq_3rd", {31'h0, irq}, 32'h1);
        bus_read("single_vec", 2'd2, 32'h8000_0002);
        bus_read("single_pend", 2'd0, 32'h4);
        bus_write(2'd3, 32'h0);
        chk("single_ackdrop", {31'h0, irq}, 32'h0);
        bus_read("single_pend_clr", 2'd0, 32'h0);
        tick();
        tick();
        chk("single_noregrant", {31'h0, irq}, 32'h0);
        src_in = 4'h0;

        // Round robin from rr_ptr=0
        do_reset();
        bus_write(2'd1, 32'hF);
        grant_q.push_back(32'h8000_0000);
        grant_q.push_back(32'h8000_0001);
        grant_q.push_back(32'h8000_0003);
        src_in = 4'b1011;
        take_grant("rr_a");
        take_grant("rr_b");
        take_grant("rr_c");
        src_in = 4'h0;
        tick();
        tick();
        grant_q.push_back(32'h8000_0000);
        grant_q.push_back(32'h8000_0003);
        src_in = 4'b1001;
        take_grant("rr_wrap_a");
        take_grant("rr_wrap_b");

        // Masked source latches pending but is never granted
        src_in = 4'h0;
        tick();
        tick();
        bus_write(2'd1, 32'hE);
        src_in = 4'b0001;
        tick();
        tick();
        tick();
        bus_read("mask_pend", 2'd0, 32'h1);
        saw_irq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_irq = saw_irq | irq;
        end
        chk("mask_noirq", {31'h0, saw_irq}, 32'h0);
        bus_write(2'd1, 32'hF);
        tick();
        chk("mask_unmask_irq", {31'h0, irq}, 32'h1);
        bus_read("mask_vec", 2'd2, 32'h8000_0000);
        bus_write(2'd3, 32'h0);

        // Collision: new edge on the granted source in the ACK clock
        src_in = 4'h0;
        tick();
        tick();
        grant_q.push_back(32'h8000_0001);
        src_in = 4'b0010;
        wait_irq("col_irq", 8);
        bus_read("col_vec", 2'd2, grant_q.pop_front());
        src_in = 4'h0;
        tick();
        tick();
        src_in = 4'b0010;
        tick();
        bus_write(2'd3, 32'h0);
        chk("col_release", {31'h0, irq}, 32'h0);
        bus_read("col_pend", 2'd0, 32'h2);
        grant_q.push_back(32'h8000_0001);
        take_grant("col_regrant");

        // Held level produces a single grant
        src_in = 4'h0;
        tick();
        tick();
        src_in = 4'b0001;
        grants = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (irq === 1'b1) begin
                grants++;
                bus_write(2'd3, 32'h0);
            end
        end
        chk("level_grants", 32'(grants), 32'd1);
        bus_read("level_pend", 2'd0, 32'h0);

        // ACK while IDLE is ignored (rr_ptr=1 -> grant 2 before 0)
        src_in = 4'h0;
        tick();
        tick();
        bus_write(2'd1, 32'h0);
        src_in = 4'b0101;
        tick();
        tick();
        tick();
        bus_read("idle_pend", 2'd0, 32'h5);
        bus_write(2'd3, 32'h0);
        bus_read("idle_ack_pend", 2'd0, 32'h5);
        grant_q.push_back(32'h8000_0002);
        grant_q.push_back(32'h8000_0000);
        bus_write(2'd1, 32'hF);
        take_grant("idle_rr_a");
        take_grant("idle_rr_b");

        // Asynchronous reset mid-GRANTED
        src_in = 4'h0;
        tick();
        tick();
        src_in = 4'b1000;
        wait_irq("areset_pre", 8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_irq", {31'h0, irq}, 32'h0);
        src_in = 4'h0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("areset_irq_after", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) bus_read("areset_reg", 2'(a), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
